// File: rtl/register_file_mp.sv
// Multi-write-port register file with per-register load scoreboard (busy bits).
// Optional define REGFILE_WRITE_BYPASS_EN: reads see this cycle's incoming writes and busy updates.

module register_file_mp_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [DATA_W-1:0] d_a,
  input  logic [DATA_W-1:0] d_b,
  input  logic              bset,
  output logic [DATA_W-1:0] rd_q,
  output logic              rd_busy
);
  logic [DATA_W-1:0] q, q_nxt;
  logic              busy, busy_nxt;

  // B is the load return and overrides A; a new load issue overrides its own completion.
  assign q_nxt    = we_b ? d_b : (we_a ? d_a : q);
  assign busy_nxt = bset ? 1'b1 : (we_b ? 1'b0 : busy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      busy <= 1'b0;
    end else begin
      q    <= q_nxt;
      busy <= busy_nxt;
    end
  end

`ifdef REGFILE_WRITE_BYPASS_EN
  assign rd_q    = q_nxt;
  assign rd_busy = busy_nxt;
`else
  assign rd_q    = q;
  assign rd_busy = busy;
`endif
endmodule

module register_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en_a,
  input  logic [ADDR_W-1:0] wr_addr_a,
  input  logic [DATA_W-1:0] wr_data_a,
  input  logic              wr_en_b,
  input  logic [ADDR_W-1:0] wr_addr_b,
  input  logic [DATA_W-1:0] wr_data_b,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_addr,
  output logic              wr_collide
);
  localparam int NUM_REGS = 1 << ADDR_W;

  logic [NUM_REGS-1:0][DATA_W-1:0] rd_q;
  logic [NUM_REGS-1:0]             rd_bz;
  logic [NUM_REGS-1:0]             we_a, we_b, bset;
  logic                            zero1, zero2, zero_wr;

  genvar i;
  generate
    for (i = 0; i < NUM_REGS; i++) begin : g_reg
      // With ZERO_REG the r0 cell never sees a write or busy_set, so it holds its reset zero.
      localparam bit KEEP = !((ZERO_REG != 0) && (i == 0));
      assign we_a[i] = KEEP && wr_en_a  && (wr_addr_a == ADDR_W'(i));
      assign we_b[i] = KEEP && wr_en_b  && (wr_addr_b == ADDR_W'(i));
      assign bset[i] = KEEP && busy_set && (busy_addr == ADDR_W'(i));

      register_file_mp_cell #(.DATA_W(DATA_W)) u_cell (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_a    (we_a[i]),
        .we_b    (we_b[i]),
        .d_a     (wr_data_a),
        .d_b     (wr_data_b),
        .bset    (bset[i]),
        .rd_q    (rd_q[i]),
        .rd_busy (rd_bz[i])
      );
    end
  endgenerate

  assign zero1   = (ZERO_REG != 0) && (rd_addr1 == '0);
  assign zero2   = (ZERO_REG != 0) && (rd_addr2 == '0);
  assign zero_wr = (ZERO_REG != 0) && (wr_addr_a == '0);

  assign rd_data1 = zero1 ? '0   : rd_q[rd_addr1];
  assign rd_data2 = zero2 ? '0   : rd_q[rd_addr2];
  assign rd_busy1 = zero1 ? 1'b0 : rd_bz[rd_addr1];
  assign rd_busy2 = zero2 ? 1'b0 : rd_bz[rd_addr2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_collide <= 1'b0;
    else        wr_collide <= wr_en_a && wr_en_b && (wr_addr_a == wr_addr_b) && !zero_wr;
  end
endmodule
